// File: rtl/baccarat_sequencer.sv
// Control FSM for one hand of Baccarat: issues card-register load strobes in deal
// order, applies the natural / third-card rules on live datapath scores, then declares the winner.
module baccarat_sequencer (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       advance,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win,
  output logic       dealer_win,
  output logic       done,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_P1     = 3'd0,
    S_D1     = 3'd1,
    S_P2     = 3'd2,
    S_D2     = 3'd3,
    S_CHK    = 3'd4,
    S_BNK3   = 3'd5,
    S_RESULT = 3'd6
  } state_t;

  state_t state_q, state_d;

  // Handshake: advance acts as a one-cycle valid with the FSM always ready; a step
  // (and its strobe) happens exactly on edges where advance=1 and reset=0.
  logic step;
  assign step = advance & ~reset;

  // Pip value of a card code; face cards, tens and invalid codes count zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    if (code >= 4'd1 && code <= 4'd9) card_value = code;
    else                              card_value = 4'd0;
  endfunction

  // Banker third-card tableau, given the player's third-card value v.
  function automatic logic banker_draws(input logic [3:0] ds, input logic [3:0] v);
    logic draw;
    draw = 1'b0;
    if (ds <= 4'd2)                                   draw = 1'b1;
    else if (ds == 4'd3)                              draw = (v != 4'd8);
    else if (ds == 4'd4)                              draw = (v >= 4'd2) && (v <= 4'd7);
    else if (ds == 4'd5)                              draw = (v >= 4'd4) && (v <= 4'd7);
    else if (ds == 4'd6)                              draw = (v >= 4'd6) && (v <= 4'd7);
    banker_draws = draw;
  endfunction

  logic       natural_hand;
  logic       player_draws;
  logic       dealer_draws_on_stand;
  logic       dealer_draws_after_p3;
  logic [3:0] p3_value;

  assign natural_hand          = (pscore >= 4'd8) || (dscore >= 4'd8);
  assign player_draws          = (pscore <= 4'd5);
  assign dealer_draws_on_stand = (dscore <= 4'd5);
  assign p3_value              = card_value(pcard3);
  assign dealer_draws_after_p3 = banker_draws(dscore, p3_value);

  always_ff @(posedge slow_clock) begin
    if (reset) state_q <= S_P1;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (advance) begin
      case (state_q)
        S_P1:     state_d = S_D1;
        S_D1:     state_d = S_P2;
        S_P2:     state_d = S_D2;
        S_D2:     state_d = S_CHK;
        S_CHK: begin
          if (natural_hand)      state_d = S_RESULT;
          else if (player_draws) state_d = S_BNK3;
          else                   state_d = S_RESULT;
        end
        S_BNK3:   state_d = S_RESULT;
        S_RESULT: state_d = S_RESULT;
        default:  state_d = S_P1;
      endcase
    end else if (state_q > S_RESULT) begin
      state_d = S_P1;
    end
  end

  // Strobes are Mealy so the datapath captures on the same edge the FSM moves.
  always_comb begin
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    player_win  = 1'b0;
    dealer_win  = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_P1: load_pcard1 = step;
      S_D1: load_dcard1 = step;
      S_P2: load_pcard2 = step;
      S_D2: load_dcard2 = step;
      S_CHK: begin
        if (!natural_hand) begin
          if (player_draws)               load_pcard3 = step;
          else if (dealer_draws_on_stand) load_dcard3 = step;
        end
      end
      S_BNK3: load_dcard3 = step & dealer_draws_after_p3;
      S_RESULT: begin
        done       = ~reset;
        player_win = ~reset & (pscore >= dscore);
        dealer_win = ~reset & (dscore >= pscore);
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Bench for baccarat_sequencer: acts as the card datapath, predicts each hand's strobe
// sequence and winner from the card values, and compares the DUT on every falling edge.
module tb_baccarat_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       advance;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win, dealer_win, done;
  logic [2:0] dbg_state;

  baccarat_sequencer dut (
    .slow_clock (clk),
    .reset      (reset),
    .advance    (advance),
    .pscore     (pscore),
    .dscore     (dscore),
    .pcard3     (pcard3),
    .load_pcard1(load_pcard1),
    .load_pcard2(load_pcard2),
    .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1),
    .load_dcard2(load_dcard2),
    .load_dcard3(load_dcard3),
    .player_win (player_win),
    .dealer_win (dealer_win),
    .done       (done),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Strobe vector order: {p1, d1, p2, d2, p3, d3}
  localparam logic [5:0] B_P1 = 6'b100000;
  localparam logic [5:0] B_D1 = 6'b010000;
  localparam logic [5:0] B_P2 = 6'b001000;
  localparam logic [5:0] B_D2 = 6'b000100;
  localparam logic [5:0] B_P3 = 6'b000010;
  localparam logic [5:0] B_D3 = 6'b000001;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- datapath stand-in ----------------
  logic [3:0] c_p1, c_d1, c_p2, c_d2, c_p3, c_d3;
  logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;

  function automatic int val(input logic [3:0] c);
    return (c >= 1 && c <= 9) ? int'(c) : 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      pc1 <= 0; pc2 <= 0; pc3 <= 0; dc1 <= 0; dc2 <= 0; dc3 <= 0;
    end else begin
      if (load_pcard1) pc1 <= c_p1;
      if (load_pcard2) pc2 <= c_p2;
      if (load_pcard3) pc3 <= c_p3;
      if (load_dcard1) dc1 <= c_d1;
      if (load_dcard2) dc2 <= c_d2;
      if (load_dcard3) dc3 <= c_d3;
    end
  end

  assign pscore = 4'((val(pc1) + val(pc2) + val(pc3)) % 10);
  assign dscore = 4'((val(dc1) + val(dc2) + val(dc3)) % 10);
  assign pcard3 = pc3;

  // ---------------- reference model ----------------
  logic [5:0] seq [6];
  int         hand_len = 4;
  int         k = 0;
  int         fin_p, fin_d;

  function automatic logic dealer_rule(input int ds, input int v);
    if (ds <= 2) return 1'b1;
    case (ds)
      3: return v != 8;
      4: return v inside {[2:7]};
      5: return v inside {[4:7]};
      6: return v inside {[6:7]};
      default: return 1'b0;
    endcase
  endfunction

  task automatic build_model();
    int ps, ds;
    ps = (val(c_p1) + val(c_p2)) % 10;
    ds = (val(c_d1) + val(c_d2)) % 10;
    seq[0] = B_P1; seq[1] = B_D1; seq[2] = B_P2; seq[3] = B_D2;
    seq[4] = 6'd0; seq[5] = 6'd0;
    fin_p = ps; fin_d = ds;
    if (ps >= 8 || ds >= 8) begin
      hand_len = 5;
    end else if (ps <= 5) begin
      seq[4] = B_P3;
      fin_p = (ps + val(c_p3)) % 10;
      if (dealer_rule(ds, val(c_p3))) begin
        seq[5] = B_D3;
        fin_d = (ds + val(c_d3)) % 10;
      end
      hand_len = 6;
    end else if (ds <= 5) begin
      seq[4] = B_D3;
      fin_d = (ds + val(c_d3)) % 10;
      hand_len = 5;
    end else begin
      hand_len = 5;
    end
  endtask

  always @(posedge clk) begin
    if (reset) k <= 0;
    else if (advance && k < hand_len) k <= k + 1;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  int cnt_p1 = 0, cnt_d1 = 0;

  always @(negedge clk) begin
    logic [5:0] exp_str;
    logic       exp_done;
    exp_str  = (!reset && advance && k < hand_len) ? seq[k] : 6'd0;
    exp_done = !reset && (k == hand_len);
    chk("strobes", {26'd0, load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3},
        {26'd0, exp_str});
    chk("done", {31'd0, done}, {31'd0, exp_done});
    chk("player_win", {31'd0, player_win}, {31'd0, exp_done && (fin_p >= fin_d)});
    chk("dealer_win", {31'd0, dealer_win}, {31'd0, exp_done && (fin_d >= fin_p)});
    cnt_p1 += int'(load_pcard1);
    cnt_d1 += int'(load_dcard1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic adv, input logic rst);
    advance = adv;
    reset   = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic new_hand(input logic [3:0] p1, d1, p2, d2, p3, d3);
    c_p1 = p1; c_d1 = d1; c_p2 = p2; c_d2 = d2; c_p3 = p3; c_d3 = d3;
    build_model();
    tick(1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic advance_to(input int target, input int gap_max, input int rst_odds);
    int guard = 0;
    while (k < target && guard < 400) begin
      if (rst_odds > 0 && $urandom_range(1, rst_odds) == 1)
        tick(1'($urandom_range(0, 1)), 1'b1);
      else
        tick($urandom_range(0, gap_max) == 0, 1'b0);
      guard++;
    end
    if (k < target) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout reaching step %0d (at %0d)", target, k);
    end
  endtask

  task automatic finish_hand(input int gap_max, input int rst_odds);
    advance_to(hand_len, gap_max, rst_odds);
    for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)), 1'b0);
  endtask

  function automatic logic [3:0] rnd_card();
    return 4'($urandom_range(1, 13));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    advance = 1'b0;
    c_p1 = 1; c_d1 = 1; c_p2 = 1; c_d2 = 1; c_p3 = 1; c_d3 = 1;
    build_model();
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk("reset_done", {31'd0, done}, 32'd0);

    // Natural: player 8, dealer 3
    new_hand(3, 1, 5, 2, 4, 4);
    chk("nat_len", hand_len, 5);
    advance_to(4, 2, 0);
    tick(1'b1, 1'b0);
    chk("nat_done", {31'd0, done}, 32'd1);
    chk("nat_pwin", {31'd0, player_win}, 32'd1);
    chk("nat_dwin", {31'd0, dealer_win}, 32'd0);
    finish_hand(1, 0);

    // Player draws 5 on 4, dealer stands on 6 -> 9 vs 6
    new_hand(1, 2, 3, 4, 5, 9);
    chk("pd_len", hand_len, 6);
    chk("pd_bnk", {26'd0, seq[5]}, 32'd0);
    finish_hand(2, 0);
    chk("pd_pwin", {31'd0, player_win}, 32'd1);
    chk("pd_dwin", {31'd0, dealer_win}, 32'd0);

    // Banker on 3, player third card 8 -> stand; 0 vs 3
    new_hand(1, 1, 1, 2, 8, 4);
    chk("b3v8_bnk", {26'd0, seq[5]}, 32'd0);
    finish_hand(0, 0);
    chk("b3v8_pwin", {31'd0, player_win}, 32'd0);
    chk("b3v8_dwin", {31'd0, dealer_win}, 32'd1);

    // Banker on 3, player third card Q (v=0) -> draw 4; 2 vs 7
    new_hand(1, 1, 1, 2, 12, 4);
    chk("b3q_bnk", {26'd0, seq[5]}, {26'd0, B_D3});
    finish_hand(1, 0);
    chk("b3q_dwin", {31'd0, dealer_win}, 32'd1);

    // Player stands on 7, dealer draws on 5 -> 7 vs 7 tie
    new_hand(3, 2, 4, 3, 9, 2);
    chk("sd_len", hand_len, 5);
    finish_hand(1, 0);
    chk("tie_pwin", {31'd0, player_win}, 32'd1);
    chk("tie_dwin", {31'd0, dealer_win}, 32'd1);

    // Advance gating in D1
    new_hand(2, 3, 2, 3, 6, 7);
    advance_to(1, 0, 0);
    cnt_d1 = 0;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("d1_pulses", cnt_d1, 1);
    finish_hand(1, 0);

    // Reset in BNK3 with advance high
    new_hand(1, 2, 3, 4, 5, 9);
    advance_to(5, 1, 0);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    chk("rst_done", {31'd0, done}, 32'd0);
    cnt_p1 = 0;
    tick(1'b1, 1'b0);
    chk("rst_p1", cnt_p1, 1);
    finish_hand(1, 0);

    // Random hands with random gaps and occasional mid-hand resets
    for (int h = 0; h < 80; h++) begin
      new_hand(rnd_card(), rnd_card(), rnd_card(), rnd_card(), rnd_card(), rnd_card());
      finish_hand($urandom_range(0, 3), (h % 4 == 0) ? 25 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
